ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch_pkg.sv | 14 +
 rtl/ifetch_fifo.sv | 65 ++++++
 rtl/ifetch.sv | 143 ++++++++++++++
 tb/tb_ifetch.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch unit.
package ifetch_pkg;

    // Fetch FSM states:
    //   ST_IDLE - no request outstanding
    //   ST_WAIT - request outstanding, its response will be buffered
    //   ST_DROP - request outstanding, its response will be discarded (redirected away)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous first-word-fall-through FIFO with a flush input.
// Head entry is visible on o_data whenever o_valid is high; o_data reads 0 when empty.
module ifetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    // A flush wins over any same-cycle push or pop.
    assign w_do_push = i_push && !i_flush;
    assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because o_data is gated by o_valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: issues one word request at a time to instruction memory,
// buffers returned instructions with their PC, and handles branch redirects.
`ifndef CFG_INST_ADDR_WIDTH
`define CFG_INST_ADDR_WIDTH 16
`endif
`ifndef CFG_INST_DATA_WIDTH
`define CFG_INST_DATA_WIDTH 32
`endif

module ifetch
    import ifetch_pkg::*;
#(
    parameter int                         INST_ADDR_WIDTH = `CFG_INST_ADDR_WIDTH,
    parameter int                         INST_DATA_WIDTH = `CFG_INST_DATA_WIDTH,
    parameter int                         FIFO_DEPTH      = 4,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_en,
    input  logic                       redirect_valid,
    input  logic [INST_ADDR_WIDTH-1:0] redirect_pc,
    output logic                       imem_req,
    output logic [INST_ADDR_WIDTH-1:0] imem_address,
    input  logic                       imem_ack,
    input  logic [INST_DATA_WIDTH-1:0] imem_data_in,
    output logic                       inst_valid,
    output logic [INST_DATA_WIDTH-1:0] inst_data,
    output logic [INST_ADDR_WIDTH-1:0] inst_pc,
    input  logic                       inst_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = INST_ADDR_WIDTH + INST_DATA_WIDTH;
    localparam logic [INST_ADDR_WIDTH-1:0] PC_ONE = {{(INST_ADDR_WIDTH-1){1'b0}}, 1'b1};

    fetch_state_e               r_state;
    logic [INST_ADDR_WIDTH-1:0] r_pc;
    logic                       r_req;
    logic [INST_ADDR_WIDTH-1:0] r_addr;
    logic                       r_first;

    logic          w_outstanding;
    logic          w_ack;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_fifo_count;
    logic [CW-1:0] w_inflight;
    logic [EW-1:0] w_fifo_out;

    // An ack only counts once the request has been visible for at least one cycle.
    assign w_outstanding = (r_state != ST_IDLE);
    assign w_ack         = imem_ack && r_req && !r_first;

    // Buffered entries plus the in-flight one must leave room, so a push never overflows.
    assign w_inflight = w_fifo_count + CW'(w_outstanding);
    assign w_issue    = fetch_en && !redirect_valid && (w_inflight < CW'(FIFO_DEPTH));

    assign w_push = (r_state == ST_WAIT) && w_ack && !redirect_valid;
    assign w_pop  = inst_valid && inst_ready;

    // Fetch FSM: request issue, response tracking and redirect handling.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_req   <= 1'b0;
            r_addr  <= RESET_PC;
            r_first <= 1'b0;
        end else begin
            r_first <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                    end else if (w_issue) begin
                        r_state <= ST_WAIT;
                        r_req   <= 1'b1;
                        r_addr  <= r_pc;
                        r_pc    <= r_pc + PC_ONE;
                        r_first <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                        if (w_ack) begin
                            r_state <= ST_IDLE;
                            r_req   <= 1'b0;
                        end else begin
                            // Keep the stale request on the bus until memory answers it.
                            r_state <= ST_DROP;
                        end
                    end else if (w_ack) begin
                        if (w_issue) begin
                            r_addr  <= r_pc;
                            r_pc    <= r_pc + PC_ONE;
                            r_first <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_req   <= 1'b0;
                        end
                    end
                end
                ST_DROP: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                    end
                    if (w_ack) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    ifetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_data  ({r_addr, imem_data_in}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_out),
        .o_valid (inst_valid),
        .o_count (w_fifo_count)
    );

    assign imem_req     = r_req;
    assign imem_address = r_addr;
    assign inst_pc      = w_fifo_out[EW-1:INST_DATA_WIDTH];
    assign inst_data    = w_fifo_out[INST_DATA_WIDTH-1:0];

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: memory responder model plus scoreboards for
// issued addresses and delivered instructions, all stepped from one process.
module tb_ifetch;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fetch_en = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          imem_req;
    logic [AW-1:0] imem_address;
    logic          imem_ack = 1'b0;
    logic [DW-1:0] imem_data_in;
    logic          inst_valid;
    logic [DW-1:0] inst_data;
    logic [AW-1:0] inst_pc;
    logic          inst_ready = 1'b0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {16'hC0DE, a, ~a};
    endfunction

    assign imem_data_in = mem_word(imem_address);

    ifetch #(
        .INST_ADDR_WIDTH (AW),
        .INST_DATA_WIDTH (DW),
        .FIFO_DEPTH      (DEPTH),
        .RESET_PC        ('0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_address   (imem_address),
        .imem_ack       (imem_ack),
        .imem_data_in   (imem_data_in),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] exp_addr[$];
    logic [AW-1:0] exp_inst[$];

    // memory model state
    logic          m_prev_req = 1'b0;
    logic          m_prev_ack = 1'b0;
    logic [AW-1:0] m_prev_addr = '0;
    int            m_cnt = 0;
    int            issue_count = 0;
    int            ack_delay = 1;
    logic          slow_en = 1'b0;
    logic [AW-1:0] slow_addr = '0;
    int            slow_delay = 3;
    logic          mem_mute = 1'b0;
    logic          manual_ack = 1'b0;
    // redirect hook: 1 = fire on first cycle of a request to hook_addr, 2 = fire on its ack
    int            hook_mode = 0;
    logic [AW-1:0] hook_addr = '0;
    logic [AW-1:0] hook_pc = '0;
    logic          hook_done = 1'b0;

    // One clock cycle: memory responds, scoreboards check, then the edge passes.
    task automatic cycle();
        logic          new_req;
        logic          fired;
        int            target;
        logic [AW-1:0] e;
        new_req = 1'b0;
        fired   = 1'b0;
        if (imem_req) begin
            new_req = !m_prev_req || m_prev_ack || (imem_address != m_prev_addr);
            if (new_req) begin
                m_cnt = 0;
                issue_count++;
                $display("req  addr=%02h", imem_address);
                if (exp_addr.size() > 0) begin
                    e = exp_addr.pop_front();
                    checks++;
                    if (imem_address !== e) begin
                        errors++;
                        $display("FAIL req_addr: got %02h, required %02h", imem_address, e);
                    end
                end
            end else begin
                m_cnt++;
            end
            target   = (slow_en && imem_address == slow_addr) ? slow_delay : ack_delay;
            imem_ack = (!mem_mute && m_cnt == target) || manual_ack;
        end else begin
            imem_ack = manual_ack;
        end
        if (hook_mode == 1 && new_req && imem_address == hook_addr) fired = 1'b1;
        if (hook_mode == 2 && imem_req && imem_ack && imem_address == hook_addr) fired = 1'b1;
        if (fired) begin
            redirect_valid = 1'b1;
            redirect_pc    = hook_pc;
            hook_mode      = 0;
        end
        if (!reset && inst_valid && inst_ready) begin
            $display("inst pc=%02h data=%08h", inst_pc, inst_data);
            if (exp_inst.size() > 0) begin
                e = exp_inst.pop_front();
                checks++;
                if (inst_pc !== e || inst_data !== mem_word(e)) begin
                    errors++;
                    $display("FAIL inst_out: got pc=%02h data=%08h, required pc=%02h data=%08h",
                             inst_pc, inst_data, e, mem_word(e));
                end
            end
        end
        m_prev_req  = imem_req;
        m_prev_ack  = imem_ack;
        m_prev_addr = imem_address;
        @(negedge clk);
        if (fired) begin
            redirect_valid = 1'b0;
            hook_done      = 1'b1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; fetch_en = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
        manual_ack = 1'b0; mem_mute = 1'b0; slow_en = 1'b0; ack_delay = 1;
        hook_mode = 0; hook_done = 1'b0;
        exp_addr.delete();
        exp_inst.delete();
        cycle();
        cycle();
        issue_count = 0;
        reset = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cycles, output int used);
        used = 0;
        while ((exp_addr.size() != 0 || exp_inst.size() != 0) && used < max_cycles) begin
            cycle();
            used++;
        end
        checks++;
        if (exp_addr.size() != 0 || exp_inst.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d addr and %0d inst pending after %0d cycles, required none",
                     name, exp_addr.size(), exp_inst.size(), used);
        end
    endtask

    task automatic test_reset();
        int i;
        reset = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h33; inst_ready = 1'b1;
        for (i = 0; i < 3; i++) cycle();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, required 0", imem_req); end
        checks++; if (imem_address !== 8'h00) begin errors++; $display("FAIL reset_addr: got %02h, required 00", imem_address); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", inst_valid); end
        checks++; if (inst_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %08h, required 0", inst_data); end
        checks++; if (inst_pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %02h, required 00", inst_pc); end
        redirect_valid = 1'b0;
    endtask

    task automatic test_stream();
        int used;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            exp_addr.push_back(AW'(i));
            exp_inst.push_back(AW'(i));
        end
        fetch_en = 1'b1; inst_ready = 1'b1;
        drain("stream", 40, used);
        checks++;
        if (used > 19) begin
            errors++;
            $display("FAIL back_to_back: 8 instructions took %0d cycles, required at most 19", used);
        end
    endtask

    task automatic test_backpressure();
        int used;
        apply_reset();
        for (int i = 0; i < 4; i++) exp_addr.push_back(AW'(i));
        fetch_en = 1'b1; inst_ready = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        checks++; if (issue_count != 4) begin errors++; $display("FAIL bp_issues: got %0d, required 4", issue_count); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req: got %b, required 0", imem_req); end
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b, required 1", inst_valid); end
        checks++; if (inst_pc !== 8'h00 || inst_data !== mem_word(8'h00)) begin
            errors++; $display("FAIL bp_head: got pc=%02h data=%08h, required pc=00 data=%08h", inst_pc, inst_data, mem_word(8'h00));
        end
        exp_addr.push_back(8'h04);
        for (int i = 0; i < 5; i++) exp_inst.push_back(AW'(i));
        inst_ready = 1'b1;
        drain("bp_resume", 40, used);
    endtask

    task automatic test_redirect_wait();
        int used;
        apply_reset();
        for (int i = 0; i < 6; i++) exp_addr.push_back(AW'(i));
        for (int i = 0; i < 5; i++) exp_inst.push_back(AW'(i));
        exp_addr.push_back(8'h40); exp_addr.push_back(8'h41);
        exp_inst.push_back(8'h40); exp_inst.push_back(8'h41);
        slow_en = 1'b1; slow_addr = 8'h05; slow_delay = 3;
        hook_mode = 1; hook_addr = 8'h05; hook_pc = 8'h40;
        fetch_en = 1'b1; inst_ready = 1'b1;
        used = 0;
        while (!hook_done && used < 40) begin cycle(); used++; end
        checks++; if (!hook_done) begin errors++; $display("FAIL rw_hook: redirect not triggered, required trigger at addr 05"); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rw_flush: inst_valid=%b, required 0", inst_valid); end
        cycle();
        cycle();
        checks++; if (imem_req !== 1'b1 || imem_address !== 8'h05) begin
            errors++; $display("FAIL rw_hold: got req=%b addr=%02h, required req=1 addr=05", imem_req, imem_address);
        end
        drain("redirect_wait", 40, used);
    endtask

    task automatic test_redirect_ack();
        int used;
        apply_reset();
        exp_addr.push_back(8'h00); exp_addr.push_back(8'h01);
        exp_addr.push_back(8'h02); exp_addr.push_back(8'h80);
        ack_delay = 2;
        hook_mode = 2; hook_addr = 8'h02; hook_pc = 8'h80;
        fetch_en = 1'b1; inst_ready = 1'b0;
        used = 0;
        while (!hook_done && used < 40) begin cycle(); used++; end
        checks++; if (!hook_done) begin errors++; $display("FAIL ra_hook: redirect not triggered, required trigger on ack of 02"); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL ra_flush: inst_valid=%b, required 0", inst_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ra_idle: imem_req=%b, required 0", imem_req); end
        exp_inst.push_back(8'h80); exp_inst.push_back(8'h81);
        inst_ready = 1'b1;
        drain("redirect_ack", 40, used);
    endtask

    task automatic test_reset_mid();
        int used;
        apply_reset();
        exp_addr.push_back(8'h00);
        mem_mute = 1'b1; fetch_en = 1'b1; inst_ready = 1'b1;
        used = 0;
        while (!imem_req && used < 10) begin cycle(); used++; end
        cycle();
        reset = 1'b1;
        cycle();
        checks++; if (imem_req !== 1'b0 || imem_address !== 8'h00) begin
            errors++; $display("FAIL rm_req: got req=%b addr=%02h, required req=0 addr=00", imem_req, imem_address);
        end
        checks++; if (inst_valid !== 1'b0 || inst_pc !== 8'h00 || inst_data !== 32'h0) begin
            errors++; $display("FAIL rm_inst: got valid=%b pc=%02h data=%08h, required 0/00/0", inst_valid, inst_pc, inst_data);
        end
        reset = 1'b0; fetch_en = 1'b0; manual_ack = 1'b1;
        cycle();
        manual_ack = 1'b0;
        cycle();
        checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL rm_stale: got valid=%b req=%b, required 0/0", inst_valid, imem_req);
        end
        mem_mute = 1'b0;
        exp_addr.push_back(8'h00);
        exp_inst.push_back(8'h00); exp_inst.push_back(8'h01);
        fetch_en = 1'b1;
        drain("reset_mid", 40, used);
    endtask

    task automatic test_wrap();
        int used;
        apply_reset();
        exp_addr.push_back(8'hFE); exp_addr.push_back(8'hFF);
        exp_addr.push_back(8'h00); exp_addr.push_back(8'h01);
        exp_inst.push_back(8'hFE); exp_inst.push_back(8'hFF);
        exp_inst.push_back(8'h00); exp_inst.push_back(8'h01);
        inst_ready = 1'b1; fetch_en = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 8'hFE;
        cycle();
        redirect_valid = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wrap_redirect_idle: imem_req=%b, required 0", imem_req); end
        drain("wrap", 40, used);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_ack();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
